data_main_memory: RTL and testbench

//  Block-granular backing store directly downstream of DataMemory_System's cache.
//  The cache issues whole-line fill reads and write-back writes. The block answers after a fixed,

---
 rtl/data_main_memory.sv | 135 +++++++++++++
 tb/tb_data_main_memory.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_main_memory.sv
// Block-granular backing store behind the data cache: whole-line fills and write-backs,
// answered after a fixed LATENCY with a one-cycle response pulse. One request in flight.
module data_main_memory #(
  parameter int unsigned data_length     = 32,
  parameter int unsigned address_length  = 10,
  parameter int unsigned words_per_block = 4,
  parameter int unsigned LATENCY         = 4
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             req_valid,
  input  logic                                             req_write,
  input  logic [address_length-$clog2(words_per_block)-1:0] req_block_addr,
  input  logic [data_length*words_per_block-1:0]           wr_line,
  output logic                                             req_ready,
  output logic                                             resp_valid,
  output logic                                             resp_write,
  output logic [data_length*words_per_block-1:0]           rd_line
);

  localparam int unsigned OFFSET_W = $clog2(words_per_block);
  localparam int unsigned BLOCK_W  = address_length - OFFSET_W;
  localparam int unsigned LINE_W   = data_length * words_per_block;
  localparam int unsigned DEPTH    = 2 ** address_length;
  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [BLOCK_W-1:0]  blk_q, blk_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   rd_line_d;
  logic                req_ready_d;
  logic                resp_valid_d;
  logic                resp_write_d;
  logic                commit_c;
  logic [LINE_W-1:0]   mem_line_c;

  // Storage array; intentionally has no reset.
  logic [data_length-1:0] mem [DEPTH];

  // Gather the captured line's words from the array.
  always_comb begin
    mem_line_c = '0;
    for (int i = 0; i < int'(words_per_block); i++) begin
      mem_line_c[i*data_length +: data_length] = mem[{blk_q, OFFSET_W'(i)}];
    end
  end

  // Write-back commit of a whole line on the final BUSY edge.
  always_ff @(posedge clock) begin
    if (commit_c) begin
      for (int i = 0; i < int'(words_per_block); i++) begin
        mem[{blk_q, OFFSET_W'(i)}] <= line_q[i*data_length +: data_length];
      end
    end
  end

  // Next-state, capture and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    blk_d     = blk_q;
    line_d    = line_q;
    rd_line_d = rd_line;
    commit_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          blk_d   = req_block_addr;
          line_d  = wr_line;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (write_q) begin
            commit_c = 1'b1;
          end else begin
            rd_line_d = mem_line_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    resp_write_d = (state_d == DONE) ? write_q : 1'b0;
  end

  // State, captured request and output registers; an async reset drops any pending request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      blk_q      <= '0;
      line_q     <= '0;
      rd_line    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      blk_q      <= blk_d;
      line_q     <= line_d;
      rd_line    <= rd_line_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_write <= resp_write_d;
    end
  end

endmodule

// File: tb/tb_data_main_memory.sv
// Self-checking bench for data_main_memory: directed table, multi-cycle corner sequences
// and randomized traffic against a word-array reference model.
module tb_data_main_memory;

  localparam int DL  = 32;
  localparam int AL  = 10;
  localparam int WPB = 4;
  localparam int LAT = 4;
  localparam int LW  = DL * WPB;
  localparam int BW  = AL - $clog2(WPB);
  localparam int NBLK = 2 ** BW;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_write;
  logic [BW-1:0] req_block_addr;
  logic [LW-1:0] wr_line;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_write;
  logic [LW-1:0] rd_line;

  data_main_memory #(
    .data_length    (DL),
    .address_length (AL),
    .words_per_block(WPB),
    .LATENCY        (LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_block_addr(req_block_addr),
    .wr_line       (wr_line),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_write    (resp_write),
    .rd_line       (rd_line)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: flat word array, word i of line b at word address b*WPB+i.
  logic [DL-1:0] model [2**AL];
  bit            written [NBLK];
  logic [LW-1:0] last_rd;

  function automatic logic [LW-1:0] model_line(input int b);
    logic [LW-1:0] l;
    for (int i = 0; i < WPB; i++) l[i*DL +: DL] = model[b*WPB + i];
    return l;
  endfunction

  task automatic model_write(input int b, input logic [LW-1:0] d);
    for (int i = 0; i < WPB; i++) model[b*WPB + i] = d[i*DL +: DL];
    written[b] = 1'b1;
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request from a negedge and return its response; checks timing along the way.
  task automatic issue(input bit w, input int blk, input logic [LW-1:0] d, input bit glitch,
                       output logic [LW-1:0] rd, output logic rw);
    int guard;
    int n;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check_bit("ready_before_req", req_ready, 1'b1);
    req_valid      = 1'b1;
    req_write      = w;
    req_block_addr = BW'(blk);
    wr_line        = d;
    @(negedge clock);
    req_valid      = 1'b0;
    req_write      = 1'($urandom);
    req_block_addr = BW'($urandom);
    wr_line        = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!resp_valid && n < 50) begin
      check_bit("busy_ready_low", req_ready, 1'b0);
      if (glitch && n == 1) req_valid = 1'b1;
      if (glitch && n == 2) req_valid = 1'b0;
      @(negedge clock);
      n++;
    end
    check_int("resp_latency", n, LAT);
    check_bit("resp_ready_low", req_ready, 1'b0);
    rd = rd_line;
    rw = resp_write;
    @(negedge clock);
    check_bit("resp_one_cycle", resp_valid, 1'b0);
    check_bit("ready_after_resp", req_ready, 1'b1);
  endtask

  // Full transaction with model bookkeeping and result checks.
  task automatic txn(input string name, input bit w, input int blk, input logic [LW-1:0] d, input bit glitch);
    logic [LW-1:0] rd;
    logic          rw;
    issue(w, blk, d, glitch, rd, rw);
    check_bit({name, "_resp_write"}, rw, w);
    if (w) begin
      check_line({name, "_rd_hold"}, rd, last_rd);
      model_write(blk, d);
    end else begin
      check_line({name, "_rd_line"}, rd, model_line(blk));
      last_rd = rd;
    end
  endtask

  typedef struct {
    bit            wr;
    int            blk;
    logic [LW-1:0] data;
  } vec_t;

  vec_t vecs [6];
  int   lines6 [4];
  int   pool [8];

  initial begin
    logic [LW-1:0] expq [$];
    int            acc_t [$];
    int            k;
    int            c;
    int            pulses;
    logic [LW-1:0] pat_a5;

    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_block_addr = '0;
    wr_line = '0;
    last_rd = '0;
    for (int i = 0; i < NBLK; i++) written[i] = 1'b0;

    vecs[0] = '{1'b1, 5,   {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[1] = '{1'b0, 5,   '0};
    vecs[2] = '{1'b1, 0,   {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000}};
    vecs[3] = '{1'b1, 255, {32'hBEEF00FF, 32'hBEEF00FE, 32'hBEEF00FD, 32'hBEEF00FC}};
    vecs[4] = '{1'b0, 0,   '0};
    vecs[5] = '{1'b0, 255, '0};

    // Reset state
    repeat (2) @(negedge clock);
    check_bit("rst_ready", req_ready, 1'b1);
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check_bit("post_rst_ready", req_ready, 1'b1);
    check_bit("post_rst_resp_valid", resp_valid, 1'b0);
    check_bit("post_rst_resp_write", resp_write, 1'b0);
    check_line("post_rst_rd_line", rd_line, '0);

    // Directed table: write/read line 5 and the address extremes
    for (int i = 0; i < 6; i++) txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].blk, vecs[i].data, 1'b0);
    check_line("line5_literal", model_line(5), {32'h44, 32'h33, 32'h22, 32'h11});

    // Extra req_valid pulse while busy must be ignored
    txn("glitch_read", 1'b0, 5, '0, 1'b1);
    pulses = 0;
    repeat (10) begin
      if (resp_valid) pulses++;
      @(negedge clock);
    end
    check_int("glitch_no_extra_resp", pulses, 0);

    // Reset during a pending write drops it
    pat_a5 = {4{32'hA5A5A5A5}};
    txn("a5_write", 1'b1, 7, pat_a5, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_block_addr = BW'(7);
    wr_line = {4{32'h5A5A5A5A}};
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_bit("midrst_resp_valid", resp_valid, 1'b0);
    check_bit("midrst_ready", req_ready, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    last_rd = '0;
    pulses = 0;
    repeat (8) begin
      if (resp_valid) pulses++;
      @(negedge clock);
    end
    check_int("midrst_no_resp", pulses, 0);
    check_line("midrst_rd_cleared", rd_line, '0);
    txn("a5_read", 1'b0, 7, '0, 1'b0);
    check_line("a5_survives", last_rd, pat_a5);

    // Randomized traffic over a small pool including the extremes
    pool = '{0, 1, 2, 3, 100, 200, 254, 255};
    for (int i = 0; i < 40; i++) begin
      int  b;
      bit  w;
      b = pool[$urandom_range(0, 7)];
      w = ($urandom_range(0, 1) == 1) || !written[b];
      txn($sformatf("rnd%0d", i), w, b, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    // Back-to-back reads with req_valid held high
    lines6 = '{5, 0, 255, 7};
    k = 0;
    c = 0;
    req_write = 1'b0;
    @(negedge clock);
    while ((k < 4 || expq.size() > 0) && c < 100) begin
      if (resp_valid) begin
        if (expq.size() == 0) begin
          check_bit("b2b_unexpected_resp", resp_valid, 1'b0);
        end else begin
          check_line("b2b_rd_line", rd_line, expq.pop_front());
          check_bit("b2b_resp_write", resp_write, 1'b0);
        end
      end
      if (req_ready) begin
        if (k < 4) begin
          req_valid = 1'b1;
          req_block_addr = BW'(lines6[k]);
          expq.push_back(model_line(lines6[k]));
          acc_t.push_back(c);
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clock);
      c++;
    end
    req_valid = 1'b0;
    check_int("b2b_accepts", acc_t.size(), 4);
    check_int("b2b_pending", expq.size(), 0);
    for (int i = 1; i < acc_t.size(); i++)
      check_int($sformatf("b2b_spacing%0d", i), acc_t[i] - acc_t[i-1], LAT + 2);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
